// File: rtl/riscv_pkg.sv
// Shared types for the memory stage: pipeline register layouts, the MEM FSM
// state encoding and the load/store width (funct3) encoding.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } ls_funct3_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    ls_funct3_e funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           rs2_data_str;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    mem_ctrl_t                 ctrl;
    logic                      valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [XLEN-1:0]           result;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      valid_mem_wb;
  } mem_wb_reg_t;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never trap.
  function automatic logic is_misaligned(input ls_funct3_e f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the data memory port: store byte enables, store data
// replication across lanes, and load lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  ls_funct3_e        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   load_raw,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    lane_b = load_raw[7:0];
    case (addr_lo)
      2'd0: lane_b = load_raw[7:0];
      2'd1: lane_b = load_raw[15:8];
      2'd2: lane_b = load_raw[23:16];
      2'd3: lane_b = load_raw[31:24];
      default: lane_b = load_raw[7:0];
    endcase
    lane_h = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
  end

  // Byte enables shifted past lane 3 fall off the 4-bit vector by design.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_raw;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = load_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data memory port, stalls the front of the
// pipeline while an access is outstanding, and registers the MEM/WB result.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses instead of issuing them.
//
// Memory handshake: dmem_req is a request-valid, dmem_gnt its ready; the
// request (addr/we/wdata/be) is transferred in the cycle both are 1 and must
// stay stable until then. Every transferred request, load or store, is
// answered later by exactly one dmem_rvalid pulse carrying dmem_rdata.
module mem_stage
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  ex_mem_reg_t               ex_mem_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      stall_mem,
  output mem_wb_reg_t               mem_wb_out,
  output logic [XLEN-1:0]           mem_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                      mem_reg_write,
  output logic                      misalign_exc,
  output logic [XLEN-1:0]           misalign_addr,
  output mem_state_e                state_dbg
);

  mem_state_e      state;
  logic            mem_op;
  logic            misaligned;
  logic            issue_op;
  logic            wb_reg_write;
  logic [XLEN-1:0] load_data;

  assign mem_op       = ex_mem_in.valid_ex_mem & (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
  assign wb_reg_write = ex_mem_in.valid_ex_mem & ex_mem_in.ctrl.reg_write & (ex_mem_in.rd_addr != '0);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(ex_mem_in.ctrl.funct3, ex_mem_in.alu_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign issue_op = mem_op & ~misaligned;

  lsu_align u_align (
    .funct3     (ex_mem_in.ctrl.funct3),
    .addr_lo    (ex_mem_in.alu_result[1:0]),
    .store_data (ex_mem_in.rs2_data_str),
    .load_raw   (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  // Request and stall; the EX/MEM register is frozen while stalled so the
  // request fields come straight from it and stay stable.
  always_comb begin
    dmem_req  = ~reset & (((state == IDLE) & issue_op) | (state == REQ));
    stall_mem = ((state == IDLE) & issue_op) | (state == REQ) |
                ((state == WAIT_RSP) & ~dmem_rvalid);
  end

  assign dmem_we        = ex_mem_in.ctrl.mem_write;
  assign dmem_addr      = ex_mem_in.alu_result;
  assign mem_alu_result = ex_mem_in.alu_result;
  assign mem_rd_addr    = ex_mem_in.rd_addr;
  assign mem_reg_write  = wb_reg_write;
  assign state_dbg      = state;

  // Access FSM and MEM/WB register; every stalled edge writes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_wb_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_op) begin
            mem_wb_out <= '0;
            state      <= dmem_gnt ? WAIT_RSP : REQ;
          end else if (misaligned) begin
            mem_wb_out <= '0;
          end else begin
            mem_wb_out.result       <= ex_mem_in.alu_result;
            mem_wb_out.rd_addr      <= ex_mem_in.rd_addr;
            mem_wb_out.reg_write    <= wb_reg_write;
            mem_wb_out.valid_mem_wb <= ex_mem_in.valid_ex_mem;
          end
        end
        REQ: begin
          mem_wb_out <= '0;
          if (dmem_gnt) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            mem_wb_out.result       <= ex_mem_in.ctrl.mem_read ? load_data : ex_mem_in.alu_result;
            mem_wb_out.rd_addr      <= ex_mem_in.rd_addr;
            mem_wb_out.reg_write    <= wb_reg_write;
            mem_wb_out.valid_mem_wb <= 1'b1;
            state                   <= IDLE;
          end else begin
            mem_wb_out <= '0;
          end
        end
        default: begin
          mem_wb_out <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle registered trap pulse carrying the faulting address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc <= misaligned & (state == IDLE);
      if (misaligned && (state == IDLE)) misalign_addr <= ex_mem_in.alu_result;
    end
  end
`else
  assign misalign_exc  = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of ALU/load/store vectors with
// hand-computed results, plus sequences for reset mid-access and misalignment.
module tb_mem_stage;
  import riscv_pkg::*;

  typedef struct {
    logic        is_mem;
    logic        valid;
    logic        rd_op;
    logic        wr_op;
    ls_funct3_e  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        regw;
    logic [31:0] rdata;
    int          gnt_d;
    int          rsp_d;
    logic        stray;
    logic        chk_res;
    logic [31:0] exp_res;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_regw;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  ex_mem_reg_t         ex_mem_in;
  logic                dmem_req, dmem_we;
  logic [31:0]         dmem_addr, dmem_wdata;
  logic [3:0]          dmem_be;
  logic                dmem_gnt, dmem_rvalid;
  logic [31:0]         dmem_rdata;
  logic                stall_mem;
  mem_wb_reg_t         mem_wb_out;
  logic [31:0]         mem_alu_result;
  logic [4:0]          mem_rd_addr;
  logic                mem_reg_write;
  logic                misalign_exc;
  logic [31:0]         misalign_addr;
  mem_state_e          state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ex_mem_in      (ex_mem_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .stall_mem      (stall_mem),
    .mem_wb_out     (mem_wb_out),
    .mem_alu_result (mem_alu_result),
    .mem_rd_addr    (mem_rd_addr),
    .mem_reg_write  (mem_reg_write),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr),
    .state_dbg      (state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t alu_v(input logic [31:0] res, input logic [4:0] rd,
                                 input logic regw, input logic valid, input logic exp_regw);
    vec_t v;
    v = '{is_mem: 1'b0, valid: valid, rd_op: 1'b0, wr_op: 1'b0, f3: F3_W, addr: res,
          rs2: 32'h0, rd: rd, regw: regw, rdata: 32'h0, gnt_d: 0, rsp_d: 0, stray: 1'b0,
          chk_res: valid, exp_res: res, exp_be: 4'h0, exp_wdata: 32'h0, exp_regw: exp_regw};
    return v;
  endfunction

  function automatic vec_t ld_v(input ls_funct3_e f3, input logic [31:0] addr, input logic [4:0] rd,
                                input logic [31:0] rdata, input int gnt_d, input int rsp_d,
                                input logic stray, input logic [31:0] exp_res, input logic exp_regw);
    vec_t v;
    v = '{is_mem: 1'b1, valid: 1'b1, rd_op: 1'b1, wr_op: 1'b0, f3: f3, addr: addr,
          rs2: 32'h0, rd: rd, regw: 1'b1, rdata: rdata, gnt_d: gnt_d, rsp_d: rsp_d, stray: stray,
          chk_res: 1'b1, exp_res: exp_res, exp_be: 4'h0, exp_wdata: 32'h0, exp_regw: exp_regw};
    return v;
  endfunction

  function automatic vec_t st_v(input ls_funct3_e f3, input logic [31:0] addr, input logic [31:0] rs2,
                                input int gnt_d, input int rsp_d, input logic stray,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    vec_t v;
    v = '{is_mem: 1'b1, valid: 1'b1, rd_op: 1'b0, wr_op: 1'b1, f3: f3, addr: addr,
          rs2: rs2, rd: 5'd0, regw: 1'b0, rdata: 32'h0, gnt_d: gnt_d, rsp_d: rsp_d, stray: stray,
          chk_res: 1'b0, exp_res: 32'h0, exp_be: exp_be, exp_wdata: exp_wdata, exp_regw: 1'b0};
    return v;
  endfunction

  function automatic ex_mem_reg_t mk(input vec_t v);
    ex_mem_reg_t e;
    e                = '0;
    e.alu_result     = v.addr;
    e.rs2_data_str   = v.rs2;
    e.rd_addr        = v.rd;
    e.ctrl.mem_read  = v.rd_op;
    e.ctrl.mem_write = v.wr_op;
    e.ctrl.reg_write = v.regw;
    e.ctrl.funct3    = v.f3;
    e.valid_ex_mem   = v.valid;
    return e;
  endfunction

  // driver: apply one vector, play the memory side, check every cycle
  task automatic run_vec(input vec_t v);
    if (!v.is_mem) begin
      @(negedge clk);
      ex_mem_in = mk(v);
      #1;
      chk("fwd_result", mem_alu_result, v.addr);
      chk("fwd_rd", 32'(mem_rd_addr), 32'(v.rd));
      chk("fwd_regw", 32'(mem_reg_write), 32'(v.exp_regw));
      chk("alu_stall", 32'(stall_mem), 32'd0);
      chk("alu_req", 32'(dmem_req), 32'd0);
      @(negedge clk);
      ex_mem_in = '0;
      #1;
      chk("alu_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'(v.valid));
      chk("alu_wb_regw", 32'(mem_wb_out.reg_write), 32'(v.exp_regw));
      if (v.chk_res) begin
        chk("alu_wb_result", mem_wb_out.result, v.exp_res);
        chk("alu_wb_rd", 32'(mem_wb_out.rd_addr), 32'(v.rd));
      end
    end else begin
      for (int c = 0; c <= v.gnt_d; c++) begin
        @(negedge clk);
        if (c == 0) ex_mem_in = mk(v);
        dmem_gnt    = (c == v.gnt_d);
        dmem_rvalid = v.stray && (c < v.gnt_d);
        dmem_rdata  = 32'h5A5A5A5A;
        #1;
        chk("req_high", 32'(dmem_req), 32'd1);
        chk("req_stall", 32'(stall_mem), 32'd1);
        chk("req_addr", dmem_addr, v.addr);
        chk("req_we", 32'(dmem_we), 32'(v.wr_op));
        if (v.wr_op) begin
          chk("req_be", 32'(dmem_be), 32'(v.exp_be));
          chk("req_wdata", dmem_wdata, v.exp_wdata);
        end
        if (c > 0) begin
          chk("req_state", 32'(state_dbg), 32'(REQ));
          chk("req_bubble", 32'(mem_wb_out.valid_mem_wb), 32'd0);
        end
      end
      for (int c = 0; c < v.rsp_d; c++) begin
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        chk("wait_req", 32'(dmem_req), 32'd0);
        chk("wait_stall", 32'(stall_mem), 32'd1);
        chk("wait_state", 32'(state_dbg), 32'(WAIT_RSP));
        chk("wait_bubble", 32'(mem_wb_out.valid_mem_wb), 32'd0);
      end
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      #1;
      chk("rsp_req", 32'(dmem_req), 32'd0);
      chk("rsp_stall", 32'(stall_mem), 32'd0);
      chk("rsp_state", 32'(state_dbg), 32'(WAIT_RSP));
      chk("rsp_bubble", 32'(mem_wb_out.valid_mem_wb), 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      ex_mem_in   = '0;
      #1;
      chk("mem_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
      chk("mem_wb_regw", 32'(mem_wb_out.reg_write), 32'(v.exp_regw));
      chk("mem_wb_rd", 32'(mem_wb_out.rd_addr), 32'(v.rd));
      chk("mem_idle", 32'(state_dbg), 32'(IDLE));
      if (v.chk_res) chk("mem_wb_result", mem_wb_out.result, v.exp_res);
    end
  endtask

  initial begin
    vec_t lw;

    // vector table
    vecs.push_back(alu_v(32'h0000002A, 5'd5, 1'b1, 1'b1, 1'b1));
    vecs.push_back(alu_v(32'h00000055, 5'd0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(alu_v(32'h00000077, 5'd7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(ld_v(F3_W,  32'h100, 5'd10, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(ld_v(F3_B,  32'h103, 5'd11, 32'h80FFFFFF, 0, 0, 1'b0, 32'hFFFFFF80, 1'b1));
    vecs.push_back(ld_v(F3_BU, 32'h103, 5'd12, 32'h80FFFFFF, 0, 0, 1'b0, 32'h00000080, 1'b1));
    vecs.push_back(ld_v(F3_H,  32'h102, 5'd13, 32'h80010000, 1, 0, 1'b1, 32'hFFFF8001, 1'b1));
    vecs.push_back(ld_v(F3_HU, 32'h100, 5'd14, 32'h1234F00D, 0, 1, 1'b0, 32'h0000F00D, 1'b1));
    vecs.push_back(ld_v(F3_H,  32'h100, 5'd15, 32'h00007FFF, 0, 0, 1'b0, 32'h00007FFF, 1'b1));
    vecs.push_back(ld_v(F3_B,  32'h101, 5'd16, 32'h00007F00, 2, 0, 1'b0, 32'h0000007F, 1'b1));
    vecs.push_back(ld_v(F3_W,  32'h104, 5'd0,  32'h01020304, 0, 0, 1'b0, 32'h01020304, 1'b0));
    vecs.push_back(st_v(F3_H,  32'h102, 32'hABCD1234, 3, 0, 1'b0, 4'b1100, 32'h12341234));
    vecs.push_back(st_v(F3_B,  32'h101, 32'h000000A5, 1, 0, 1'b1, 4'b0010, 32'hA5A5A5A5));
    vecs.push_back(st_v(F3_W,  32'h200, 32'hCAFEF00D, 0, 2, 1'b0, 4'b1111, 32'hCAFEF00D));
    vecs.push_back(st_v(F3_B,  32'h103, 32'hFFFFFF3C, 0, 0, 1'b0, 4'b1000, 32'h3C3C3C3C));
    vecs.push_back(st_v(F3_H,  32'h100, 32'h0000BEEF, 2, 0, 1'b1, 4'b0011, 32'hBEEFBEEF));
    vecs.push_back(alu_v(32'h12345678, 5'd31, 1'b1, 1'b1, 1'b1));

    // reset with a load presented: no request may leak out
    lw          = ld_v(F3_W, 32'h300, 5'd9, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1);
    reset       = 1'b1;
    ex_mem_in   = mk(lw);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_wb_result", mem_wb_out.result, 32'h0);
    chk("rst_wb_ctl", {25'd0, mem_wb_out.rd_addr, mem_wb_out.reg_write, mem_wb_out.valid_mem_wb}, 32'h0);
    chk("rst_exc", 32'(misalign_exc), 32'd0);
    chk("rst_exc_addr", misalign_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ex_mem_in = '0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // reset while waiting for the response; the late rvalid must be dropped
    @(negedge clk);
    ex_mem_in = mk(lw);
    dmem_gnt  = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    chk("mid_state_wait", 32'(state_dbg), 32'(WAIT_RSP));
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    chk("mid_rst_wb", {25'd0, mem_wb_out.rd_addr, mem_wb_out.reg_write, mem_wb_out.valid_mem_wb}, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    ex_mem_in = '0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0BAD0;
    #1;
    chk("stray_req", 32'(dmem_req), 32'd0);
    chk("stray_stall", 32'(stall_mem), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("stray_state", 32'(state_dbg), 32'(IDLE));
    chk("stray_wb_result", mem_wb_out.result, 32'h0);
    chk("stray_wb_ctl", {25'd0, mem_wb_out.rd_addr, mem_wb_out.reg_write, mem_wb_out.valid_mem_wb}, 32'h0);
    run_vec(alu_v(32'h0000BEEF, 5'd5, 1'b1, 1'b1, 1'b1));

    // misaligned word load at 0x101
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    ex_mem_in = mk(ld_v(F3_W, 32'h101, 5'd3, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0));
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall_mem), 32'd0);
    @(negedge clk);
    ex_mem_in = '0;
    #1;
    chk("mis_exc", 32'(misalign_exc), 32'd1);
    chk("mis_addr", misalign_addr, 32'h101);
    chk("mis_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd0);
    chk("mis_wb_regw", 32'(mem_wb_out.reg_write), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_exc_pulse", 32'(misalign_exc), 32'd0);
`else
    run_vec(ld_v(F3_W, 32'h101, 5'd3, 32'h11223344, 0, 0, 1'b0, 32'h11223344, 1'b1));
    run_vec(st_v(F3_H, 32'h103, 32'h00005678, 1, 0, 1'b0, 4'b1100, 32'h56785678));
    chk("mis_exc_tied", 32'(misalign_exc), 32'd0);
    chk("mis_addr_tied", misalign_addr, 32'h0);
`endif

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have port: ex_mem_in  in  ex_mem_reg_t  EX/MEM register (alu_result, rs2_data_str, rd_addr, ctrl incl. mem_read/mem_write/reg_write/funct3, valid_ex_mem).
REQ-004 SHALL have ports: dmem_req out 1; dmem_we out 1; dmem_addr out XLEN; dmem_wdata out XLEN; dmem_be out 4; dmem_gnt in 1; dmem_rvalid in 1; dmem_rdata in XLEN.
REQ-005 SHALL have port: stall_mem  out  1  freezes IF/ID/EX and EX/MEM register.
REQ-006 SHALL have port: mem_wb_out  out  mem_wb_reg_t  registered MEM/WB register (result, rd_addr, reg_write, valid_mem_wb).
REQ-007 SHALL have ports: mem_alu_result out XLEN; mem_rd_addr out REG_ADDR_WIDTH; mem_reg_write out 1. These are combinational forwarding taps to EX.
REQ-008 SHALL have ports: misalign_exc out 1; misalign_addr out XLEN.

Function
REQ-009 Non-memory valid op SHALL pass to mem_wb_out at the next edge, stall_mem=0, dmem_req=0.
REQ-010 FSM states SHALL be IDLE, REQ, WAIT_RSP.
REQ-011 IDLE with a valid load/store: dmem_req=1 combinationally; on dmem_gnt go to WAIT_RSP, else go to REQ.
REQ-012 REQ: dmem_req=1, with addr/we/wdata/be held stable until dmem_gnt, then go to WAIT_RSP.
REQ-013 WAIT_RSP: dmem_req=0; on dmem_rvalid capture the result into mem_wb_out and go to IDLE; loads and stores both wait for rvalid.
REQ-014 stall_mem SHALL be 1 when there is a memory op in IDLE, in REQ, and in WAIT_RSP without rvalid; it SHALL be 0 in the rvalid cycle. Minimum memory-op latency is 2 cycles.
REQ-015 While stall_mem=1, mem_wb_out.valid_mem_wb SHALL be 0 at each edge (bubble).
REQ-016 dmem_rvalid SHALL be ignored in IDLE and REQ.
REQ-017 Store byte enables: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111. wdata SHALL replicate the low byte/half across lanes.
REQ-018 Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; the lane is selected by addr[1:0].
REQ-019 dmem_addr SHALL equal alu_result with no truncation.
REQ-020 mem_wb_out.reg_write SHALL be forced 0 when rd_addr==0 or when the op is invalid.
REQ-021 mem_reg_write SHALL be valid_ex_mem & reg_write & (rd_addr!=0). The load-use hazard is owned by the hazard unit, not this block.

Reset
REQ-022 Reset SHALL force FSM=IDLE, mem_wb_out all-zero, misalign_exc=0, misalign_addr=0.
REQ-023 Reset mid-transaction SHALL abandon the access; any later stray rvalid is ignored per REQ-016.
REQ-024 dmem_req SHALL be 0 during reset.

Configuration
REQ-025 Macro MEM_MISALIGN_TRAP_EN defined: a misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0]!=0) SHALL issue no request and raise no stall. The op SHALL retire as a bubble with reg_write=0, and misalign_exc SHALL pulse 1 cycle (registered) with misalign_addr=address.
REQ-026 Macro undefined: misalign_exc and misalign_addr SHALL be tied 0. Misaligned accesses SHALL issue as-is, with byte enables shifted beyond lane 3 dropped.

Structure
REQ-027 mem_wb_reg_t, mem_state_e and the funct3 load/store enum SHALL live in riscv_pkg.
REQ-028 Byte-enable, write-data replication and load extraction SHALL be one combinational sub-module, lsu_align.

Verification
REQ-029 ADD to x5, no memory op -> mem_wb_out valid next edge, stall_mem never 1.
REQ-030 LW at 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> stall for 1 cycle, x-result 0xDEADBEEF.
REQ-031 LB at 0x103, rdata 0x80FFFFFF -> result 0xFFFFFF80; LBU -> 0x00000080.
REQ-032 SH at 0x102, rs2 0x1234, gnt delayed 3 cycles -> be=1100, wdata=0x12341234, addr stable, stall through rvalid.
REQ-033 Reset asserted in WAIT_RSP, rvalid arrives after release -> IDLE, mem_wb_out zero, response ignored.
REQ-034 With MEM_MISALIGN_TRAP_EN, LW at 0x101 -> dmem_req=0, misalign_exc 1-cycle pulse, misalign_addr=0x101.
